// File: rtl/dct_pkg.sv
// Shared types and defaults for the block-transform scheduler and its coordinate generators.
package dct_pkg;

  typedef enum logic [1:0] {
    S_DS_IDLE,
    S_DS_LAUNCH,
    S_DS_WAIT,
    S_DS_FINISH
  } dct_sched_state_t;

  localparam logic [1:0] PLANE_Y = 2'd0;
  localparam logic [1:0] PLANE_U = 2'd1;
  localparam logic [1:0] PLANE_V = 2'd2;

  localparam int DCT_Y_COLS  = 40;
  localparam int DCT_UV_COLS = 20;
  localparam int DCT_ROWS    = 30;

endpackage

// File: rtl/dct_block_coord_gen.sv
// Walks 8x8 block coordinates plane-major, row-major, column-minor; the column
// limit depends on the plane. last flags the final V-plane block.
module dct_block_coord_gen
  import dct_pkg::*;
#(
  parameter int Y_COLS  = DCT_Y_COLS,
  parameter int UV_COLS = DCT_UV_COLS,
  parameter int ROWS    = DCT_ROWS
) (
  input  logic       CLOCK_50_I,
  input  logic       Resetn,
  input  logic       advance,
  input  logic       clear,
  output logic [1:0] plane,
  output logic [4:0] row,
  output logic [5:0] col,
  output logic       last
);

  localparam logic [5:0] Y_LIM   = 6'(Y_COLS - 1);
  localparam logic [5:0] UV_LIM  = 6'(UV_COLS - 1);
  localparam logic [4:0] ROW_LIM = 5'(ROWS - 1);

  logic [5:0] w_col_lim;

  assign w_col_lim = (plane == PLANE_Y) ? Y_LIM : UV_LIM;
  assign last      = (plane == PLANE_V) && (row == ROW_LIM) && (col == w_col_lim);

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      plane <= PLANE_Y;
      row   <= '0;
      col   <= '0;
    end else if (clear) begin
      plane <= PLANE_Y;
      row   <= '0;
      col   <= '0;
    end else if (advance) begin
      if (col == w_col_lim) begin
        col <= '0;
        if (row == ROW_LIM) begin
          row   <= '0;
          // wrap after the final block so an idle generator rests at block 0
          plane <= last ? PLANE_Y : plane + 2'd1;
        end else begin
          row <= row + 5'd1;
        end
      end else begin
        col <= col + 6'd1;
      end
    end
  end

endmodule

// File: rtl/dct_block_scheduler.sv
// Software-pipelined fetch / compute / write sequencer over all Y,U,V 8x8 blocks.
// Optional DCT_SCHED_PERF_EN adds cycle_count and stall_count performance outputs.
module dct_block_scheduler
  import dct_pkg::*;
#(
  parameter int Y_COLS  = DCT_Y_COLS,
  parameter int UV_COLS = DCT_UV_COLS,
  parameter int ROWS    = DCT_ROWS
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        start,
  output logic        done,
  output logic        busy,
  output logic        fetch_start,
  input  logic        fetch_done,
  output logic [1:0]  fetch_plane,
  output logic [4:0]  fetch_row,
  output logic [5:0]  fetch_col,
  output logic        mm_start,
  input  logic        mm_done,
  output logic        write_start,
  input  logic        write_done,
  output logic [1:0]  write_plane,
  output logic [4:0]  write_row,
  output logic [5:0]  write_col,
  output logic        buf_sel
`ifdef DCT_SCHED_PERF_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] stall_count
`endif
);

  dct_sched_state_t r_state;
  // bit 0 fetch, bit 1 compute, bit 2 write: a phase's task set shifts up each phase
  logic [2:0] r_vld_pipe;
  logic [2:0] r_pend;
  logic       r_fetch_more;

  logic [2:0] w_acc;
  logic [2:0] w_pend_nx;
  logic [2:0] w_vld_nx;
  logic       w_fmore_nx;
  logic       w_start_ok;
  logic       w_f_last;
  logic       w_w_last;

  assign w_start_ok = start && (r_state == S_DS_IDLE);
  assign w_acc      = {write_done, mm_done, fetch_done} & r_pend & {3{r_state == S_DS_WAIT}};
  assign w_pend_nx  = r_pend & ~w_acc;
  assign w_fmore_nx = r_fetch_more && !(w_acc[0] && w_f_last);
  assign w_vld_nx   = {r_vld_pipe[1:0], w_fmore_nx};

  dct_block_coord_gen #(.Y_COLS(Y_COLS), .UV_COLS(UV_COLS), .ROWS(ROWS)) u_fetch_gen (
    .CLOCK_50_I (CLOCK_50_I),
    .Resetn     (Resetn),
    .advance    (w_acc[0]),
    .clear      (w_start_ok),
    .plane      (fetch_plane),
    .row        (fetch_row),
    .col        (fetch_col),
    .last       (w_f_last)
  );

  dct_block_coord_gen #(.Y_COLS(Y_COLS), .UV_COLS(UV_COLS), .ROWS(ROWS)) u_write_gen (
    .CLOCK_50_I (CLOCK_50_I),
    .Resetn     (Resetn),
    .advance    (w_acc[2]),
    .clear      (w_start_ok),
    .plane      (write_plane),
    .row        (write_row),
    .col        (write_col),
    .last       (w_w_last)
  );

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      r_state      <= S_DS_IDLE;
      r_vld_pipe   <= '0;
      r_pend       <= '0;
      r_fetch_more <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      fetch_start  <= 1'b0;
      mm_start     <= 1'b0;
      write_start  <= 1'b0;
      buf_sel      <= 1'b0;
    end else begin
      done        <= 1'b0;
      fetch_start <= 1'b0;
      mm_start    <= 1'b0;
      write_start <= 1'b0;
      case (r_state)
        S_DS_IDLE: begin
          if (start) begin
            r_state      <= S_DS_LAUNCH;
            busy         <= 1'b1;
            buf_sel      <= 1'b0;
            r_vld_pipe   <= 3'b001;
            r_pend       <= 3'b001;
            r_fetch_more <= 1'b1;
            fetch_start  <= 1'b1;
          end
        end
        S_DS_LAUNCH: r_state <= S_DS_WAIT;
        S_DS_WAIT: begin
          r_pend       <= w_pend_nx;
          r_fetch_more <= w_fmore_nx;
          if (w_pend_nx == 3'b000) begin
            // write-only phase retiring the final block ends the frame
            if (r_vld_pipe[2] && !r_vld_pipe[1] && w_w_last) begin
              r_state <= S_DS_FINISH;
              done    <= 1'b1;
            end else begin
              r_state     <= S_DS_LAUNCH;
              r_vld_pipe  <= w_vld_nx;
              r_pend      <= w_vld_nx;
              fetch_start <= w_vld_nx[0];
              mm_start    <= w_vld_nx[1];
              write_start <= w_vld_nx[2];
              buf_sel     <= ~buf_sel;
            end
          end
        end
        S_DS_FINISH: begin
          r_state <= S_DS_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= S_DS_IDLE;
      endcase
    end
  end

`ifdef DCT_SCHED_PERF_EN
  logic w_one_pend;

  assign w_one_pend = (r_pend != 3'b000) && ((r_pend & (r_pend - 3'd1)) == 3'b000);

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else if (w_start_ok) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else if (busy) begin
      cycle_count <= cycle_count + 32'd1;
      if ((r_state == S_DS_WAIT) && w_one_pend)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
